// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and header constants for imem_loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    CHK,
    FINISH
  } imem_ld_state_t;

  localparam int LDR_HDR_BYTES = 2;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream to instruction RAM word writer
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [DEPTH-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BPW = WIDTH / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);

  imem_ld_state_t   state;
  logic [15:0]      count;
  logic [BW-1:0]    byte_cnt;
  logic [DEPTH:0]   index;
  logic [WIDTH-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic             accept;
  logic [WIDTH-1:0] next_word;
  logic [DEPTH:0]   index_next;
  logic [31:0]      hdr_n;

  assign in_ready   = state inside {HDR_LO, HDR_HI, DATA, CHK};
  assign busy       = (state != IDLE);
  assign accept     = in_valid && in_ready;
  // Little-endian assembly: newest byte enters at the top, so the first byte lands in [7:0].
  assign next_word  = (word >> 8) | (WIDTH'(in_data) << (WIDTH - 8));
  assign index_next = index + 1'b1;
  assign hdr_n      = 32'({in_data, count[7:0]});

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      byte_cnt <= '0;
      index    <= '0;
      word     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            done     <= 1'b0;
            err      <= 1'b0;
            byte_cnt <= '0;
            index    <= '0;
            word     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
            state    <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            count[7:0] <= in_data;
            state      <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (accept) begin
            count[15:8] <= in_data;
            if (hdr_n > (32'd1 << DEPTH)) begin
              err   <= 1'b1;
              state <= IDLE;
            end else if (hdr_n == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= FINISH;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word <= next_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              wr_en    <= 1'b1;
              wr_data  <= next_word;
              wr_addr  <= index[DEPTH-1:0];
              index    <= index_next;
              if (32'(index_next) == 32'(count)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state <= FINISH;
`endif
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            if (in_data == csum) begin
              state <= FINISH;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
`endif
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int BPW   = WIDTH / 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             wr_en;
  logic [DEPTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [DEPTH-1:0] addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] n;
    logic [63:0] payload;
    bit          use_pat;
    bit          gap;
    bit          start_mid;
    bit          bad_csum;
    bit          exp_err;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  got;
  logic prev_wr = 1'b0;
  vec_t vecs[7];

  imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    chk("done_err_excl", done & err, 0);
    chk("wr_en_b2b", wr_en & prev_wr, 0);
    if (wr_en) begin
      chk("unexpected_wr", exp_q.size() == 0, 0);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("wr_addr", wr_addr, got.addr);
        chk("wr_data", wr_data, got.data);
      end
    end
    prev_wr = wr_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] byte_of(input vec_t v, input int j);
    if (v.use_pat) return 8'(j * 7 + 3);
    return v.payload[8*j +: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gap, input bit pulse);
    int budget;
    if (gap) begin
      in_valid = 1'b0;
      start = pulse;
      @(negedge clk);
      start = 1'b0;
    end
    in_data = b;
    in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    logic [7:0]       cs;
    logic [WIDTH-1:0] w;
    bit               exp_err;
    exp_err = v.exp_err | (CSUM_EN & v.bad_csum);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", in_ready, 1);
    chk("start_clr", {done, err}, 0);
    send_byte(v.n[7:0], v.gap, 1'b0);
    send_byte(v.n[15:8], v.gap, 1'b0);
    cs = 8'h00;
    if (v.n <= 16'(1 << DEPTH)) begin
      for (int i = 0; i < int'(v.n); i++) begin
        for (int k = 0; k < BPW; k++) w[8*k +: 8] = byte_of(v, i * BPW + k);
        exp_q.push_back('{addr: DEPTH'(i), data: w});
        for (int k = 0; k < BPW; k++) begin
          send_byte(w[8*k +: 8], v.gap, v.start_mid && i == 0 && k == 2);
          cs = cs ^ w[8*k +: 8];
        end
      end
      if (CSUM_EN) send_byte(v.bad_csum ? (cs ^ 8'h01) : cs, v.gap, 1'b0);
    end
    if (exp_err) begin
      chk("err_set", err, 1);
      chk("err_done", done, 0);
      chk("err_busy", busy, 0);
      chk("err_ready", in_ready, 0);
    end else begin
      chk("finish_busy", busy, 1);
      chk("finish_done", done, 0);
      @(negedge clk);
      chk("done_set", done, 1);
      chk("done_err", err, 0);
      chk("idle_busy", busy, 0);
    end
    @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{n: 16'd2,   payload: 64'h00100093_00000013, use_pat: 0, gap: 0, start_mid: 0, bad_csum: 0, exp_err: 0};
    vecs[1] = '{n: 16'd0,   payload: 64'h0,                 use_pat: 0, gap: 0, start_mid: 0, bad_csum: 0, exp_err: 0};
    vecs[2] = '{n: 16'd257, payload: 64'h0,                 use_pat: 0, gap: 0, start_mid: 0, bad_csum: 0, exp_err: 1};
    vecs[3] = '{n: 16'd2,   payload: 64'h00100093_00000013, use_pat: 0, gap: 1, start_mid: 1, bad_csum: 0, exp_err: 0};
    vecs[4] = '{n: 16'd1,   payload: 64'h00000013,          use_pat: 0, gap: 0, start_mid: 0, bad_csum: 0, exp_err: 0};
    vecs[5] = '{n: 16'd1,   payload: 64'h00000013,          use_pat: 0, gap: 0, start_mid: 0, bad_csum: 1, exp_err: 0};
    vecs[6] = '{n: 16'd256, payload: 64'h0,                 use_pat: 1, gap: 0, start_mid: 0, bad_csum: 0, exp_err: 0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outs", {in_ready, wr_en, wr_addr, wr_data, busy, done, err}, 0);

    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (2) @(negedge clk);
    chk("idle_ignores_valid", {in_ready, busy}, 0);
    in_valid = 1'b0;

    for (int i = 0; i < 7; i++) run_load(vecs[i]);

    // Reset after five payload bytes: only word 0 should ever have been written.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    exp_q.push_back('{addr: DEPTH'(0), data: 32'h00000013});
    send_byte(8'h13, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h93, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midload_reset_outs", {in_ready, wr_en, wr_addr, wr_data, busy, done, err}, 0);
    repeat (2) @(negedge clk);
    chk("midload_reset_writes", exp_q.size(), 0);
    run_load(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
